// File: rtl/sm83_bitop_wr.sv
// SM83 CB-prefix SET/RES bit-write sequencer (register or (HL) operand), M-cycle timed.
// Optional BIT test path enabled by defining SM83_BITOP_BIT_EN.
//
// state | meaning
// IDLE  | waiting for start
// EXEC  | register form (or reserved op), one M-cycle
// READ  | bus read of (HL), one M-cycle
// WRITE | bus write of modified byte, one M-cycle
module sm83_bitop_wr #(
  parameter int TCYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [1:0] op,
  input  logic [2:0] bit_sel,
  input  logic       use_mem,
  input  logic [7:0] reg_in,
  input  logic [7:0] mem_rdata,
  output logic       busy,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic [7:0] mem_wdata,
  output logic [7:0] result,
  output logic       reg_we,
  output logic [2:0] flags_out,
  output logic       flags_we,
  output logic       done
);

`ifdef SM83_BITOP_BIT_EN
  localparam bit BIT_EN = 1'b1;
`else
  localparam bit BIT_EN = 1'b0;
`endif

  localparam logic [2:0] TLAST = 3'(TCYCLES - 1);

  typedef enum logic [1:0] {IDLE, EXEC, READ, WRITE} state_t;

  state_t     state, state_nx;
  logic [2:0] t, t_nx;
  logic [1:0] op_q;
  logic [2:0] bit_q;
  logic [7:0] data_q;
  logic [7:0] mask, modified;
  logic       accept, last, data_ld, wr_op, bit_op;

  function automatic logic is_write(input logic [1:0] o);
    return (o == 2'b01) || (o == 2'b10);
  endfunction

  function automatic logic is_bit(input logic [1:0] o);
    return BIT_EN && (o == 2'b00);
  endfunction

  assign mask     = 8'b1 << bit_q;
  assign modified = (op_q == 2'b10) ? (data_q | mask) : (data_q & ~mask);
  assign wr_op    = is_write(op_q);
  assign bit_op   = is_bit(op_q);
  assign last     = (t == TLAST);

  // All outputs decode from state so reset clears them without a clock edge.
  always_comb begin
    state_nx  = state;
    t_nx      = t;
    data_ld   = 1'b0;
    busy      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    result    = 8'h00;
    reg_we    = 1'b0;
    flags_out = 3'b000;
    flags_we  = 1'b0;
    done      = 1'b0;
    case (state)
      EXEC: begin
        busy = 1'b1;
        if (last) begin
          done     = 1'b1;
          state_nx = IDLE;
          if (wr_op) begin
            reg_we = 1'b1;
            result = modified;
          end
          if (bit_op) begin
            flags_we  = 1'b1;
            flags_out = {~data_q[bit_q], 2'b01};
          end
        end
      end
      READ: begin
        busy   = 1'b1;
        mem_rd = 1'b1;
        if (last) begin
          if (bit_op) begin
            done      = 1'b1;
            flags_we  = 1'b1;
            flags_out = {~mem_rdata[bit_q], 2'b01};
            state_nx  = IDLE;
          end else begin
            data_ld  = 1'b1;
            state_nx = WRITE;
          end
        end
      end
      WRITE: begin
        busy      = 1'b1;
        mem_wr    = 1'b1;
        mem_wdata = modified;
        if (last) begin
          done     = 1'b1;
          state_nx = IDLE;
        end
      end
      default: ;
    endcase
    if (state != IDLE)
      t_nx = last ? 3'd0 : t + 3'd1;
    accept = start && ((state == IDLE) || done);
    // Reserved ops never touch the bus, even when use_mem is set.
    if (accept) begin
      t_nx     = 3'd0;
      state_nx = (use_mem && (is_write(op) || is_bit(op))) ? READ : EXEC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      t      <= 3'd0;
      op_q   <= 2'b00;
      bit_q  <= 3'd0;
      data_q <= 8'h00;
    end else begin
      state <= state_nx;
      t     <= t_nx;
      if (accept) begin
        op_q   <= op;
        bit_q  <= bit_sel;
        data_q <= reg_in;
      end else if (data_ld) begin
        data_q <= mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sm83_bitop_wr.sv
// Scoreboard bench for sm83_bitop_wr: random SET/RES/BIT/reserved ops checked against a per-op model.
module tb_sm83_bitop_wr;
  localparam int T = 4;

  logic clk = 1'b0;
  logic reset;
  logic start, use_mem, busy, mem_rd, mem_wr, reg_we, flags_we, done;
  logic [1:0] op;
  logic [2:0] bit_sel, flags_out;
  logic [7:0] reg_in, mem_rdata, mem_wdata, result;

  logic start1, use_mem1, busy1, mem_rd1, mem_wr1, reg_we1, flags_we1, done1;
  logic [1:0] op1;
  logic [2:0] bit_sel1, flags_out1;
  logic [7:0] reg_in1, mem_rdata1, mem_wdata1, result1;

  always #5 clk = ~clk;

  sm83_bitop_wr #(.TCYCLES(T)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .bit_sel(bit_sel),
    .use_mem(use_mem), .reg_in(reg_in), .mem_rdata(mem_rdata), .busy(busy),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata), .result(result),
    .reg_we(reg_we), .flags_out(flags_out), .flags_we(flags_we), .done(done));

  sm83_bitop_wr #(.TCYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op1), .bit_sel(bit_sel1),
    .use_mem(use_mem1), .reg_in(reg_in1), .mem_rdata(mem_rdata1), .busy(busy1),
    .mem_rd(mem_rd1), .mem_wr(mem_wr1), .mem_wdata(mem_wdata1), .result(result1),
    .reg_we(reg_we1), .flags_out(flags_out1), .flags_we(flags_we1), .done(done1));

  typedef struct {
    int         dur;
    int         n_we;
    logic [7:0] res;
    int         n_rd;
    int         n_wr;
    logic [7:0] wd;
    int         n_fl;
    logic [2:0] fl;
  } exp_t;

  exp_t sbq[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  // Reference: what one instruction must do, from the instruction's meaning.
  function automatic exp_t model(input int tc, input int o, input int b, input int um,
                                 input int rv, input int mv);
    exp_t e;
    int v, nv;
    e = '{dur: tc, n_we: 0, res: 8'h00, n_rd: 0, n_wr: 0, wd: 8'h00, n_fl: 0, fl: 3'b000};
    v = um ? mv : rv;
    if (o == 1 || o == 2) begin
      nv = (o == 2) ? (v | (1 << b)) : (v & ~(1 << b) & 255);
      if (um) begin
        e.dur  = 2 * tc;
        e.n_rd = tc;
        e.n_wr = tc;
        e.wd   = 8'(nv);
      end else begin
        e.n_we = 1;
        e.res  = 8'(nv);
      end
    end
`ifdef SM83_BITOP_BIT_EN
    else if (o == 0) begin
      e.n_fl = 1;
      e.fl   = (((v >> b) & 1) == 0) ? 3'b101 : 3'b001;
      e.n_rd = um ? tc : 0;
    end
`endif
    return e;
  endfunction

  bit mon_en = 1'b0;
  int m_cnt, m_we, m_rd, m_wr, m_fl, m_ovl, m_unst;
  logic [7:0] m_res, m_wd;
  logic [2:0] m_fv;
  exp_t m_e;

  task automatic clear_acc();
    m_cnt = 0; m_we = 0; m_rd = 0; m_wr = 0; m_fl = 0; m_ovl = 0; m_unst = 0;
    m_res = 8'h00; m_wd = 8'h00; m_fv = 3'b000;
  endtask

  always @(negedge clk) begin
    if (!mon_en) clear_acc();
    else begin
      if (busy) m_cnt++;
      if (reg_we) begin m_we++; m_res = result; end
      if (mem_rd) m_rd++;
      if (mem_wr) begin
        if (m_wr == 0) m_wd = mem_wdata;
        else if (mem_wdata != m_wd) m_unst = 1;
        m_wr++;
      end
      if (mem_rd && mem_wr) m_ovl = 1;
      if (flags_we) begin m_fl++; m_fv = flags_out; end
      if (done) begin
        if (sbq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          m_e = sbq.pop_front();
          chk("busy_cycles", m_cnt, m_e.dur);
          chk("reg_we_count", m_we, m_e.n_we);
          if (m_e.n_we != 0) chk("result", int'(m_res), int'(m_e.res));
          chk("mem_rd_cycles", m_rd, m_e.n_rd);
          chk("mem_wr_cycles", m_wr, m_e.n_wr);
          if (m_e.n_wr != 0) chk("mem_wdata", int'(m_wd), int'(m_e.wd));
          chk("wdata_stable", m_unst, 0);
          chk("strobe_overlap", m_ovl, 0);
          chk("flags_we_count", m_fl, m_e.n_fl);
          if (m_e.n_fl != 0) chk("flags_out", int'(m_fv), int'(m_e.fl));
        end
        clear_acc();
      end
    end
  end

  // Waits for an accept slot, throwing ignored starts at the DUT while it is busy.
  task automatic issue(input int o, input int b, input int um, input int rv, input int mv);
    int k;
    bit b2b;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      #1;
      if (!busy || done) break;
      start = ($urandom_range(0, 1) == 1);
      op = 2'($urandom); bit_sel = 3'($urandom); use_mem = 1'($urandom); reg_in = 8'($urandom);
    end
    if (k == 100) chk("accept_timeout", 1, 0);
    b2b = busy && done;
    start = 1'b1; op = 2'(o); bit_sel = 3'(b); use_mem = 1'(um);
    reg_in = 8'(rv); mem_rdata = 8'(mv);
    sbq.push_back(model(T, o, b, um, rv, mv));
    if (b2b) begin
      @(negedge clk);
      chk("b2b_busy", int'(busy), 1);
      #1 start = 1'b0;
    end
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      @(negedge clk);
      #1 start = 1'b0;
    end
  endtask

  task automatic drain();
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      #1 start = 1'b0;
      if (!busy && sbq.size() == 0) break;
    end
    chk("scoreboard_drained", sbq.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k;
    exp_t e;
    reset = 1'b1;
    start = 0; op = 0; bit_sel = 0; use_mem = 0; reg_in = 0; mem_rdata = 0;
    start1 = 0; op1 = 0; bit_sel1 = 0; use_mem1 = 0; reg_in1 = 0; mem_rdata1 = 0;
    #12;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_strobes", int'({mem_rd, mem_wr, reg_we, flags_we}), 0);
    chk("rst_data", int'({mem_wdata, result, flags_out}), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    mon_en = 1'b1;

    issue(2, 3, 0, 8'h00, 8'h00);
    issue(1, 7, 1, 8'h00, 8'hA5);
    issue(2, 0, 0, 8'hFE, 8'h00);
    issue(2, 5, 0, 8'h11, 8'h00);
    issue(0, 4, 0, 8'hEF, 8'h00);
    issue(0, 0, 1, 8'h00, 8'h5B);
    issue(3, 2, 1, 8'h33, 8'h44);
    gap(3);
    for (int i = 0; i < 60; i++) begin
      issue(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
      if ($urandom_range(0, 3) == 0) gap(int'($urandom_range(1, 4)));
    end
    drain();

    // Reset in the middle of the WRITE M-cycle.
    mon_en = 1'b0;
    issue(2, 4, 1, 8'h00, 8'h00);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      #1 start = 1'b0;
      if (mem_wr) break;
    end
    chk("reach_write", int'(mem_wr), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_mem_wr", int'(mem_wr), 0);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_done", int'(done), 0);
    chk("async_rst_reg_we", int'(reg_we), 0);
    @(negedge clk);
    #1 reset = 1'b0;
    sbq.delete();
    mon_en = 1'b1;
    issue(2, 4, 0, 8'h00, 8'h00);
    issue(1, 1, 1, 8'h00, 8'hFF);
    drain();

    // Single-clock M-cycle: back-to-back register ops on consecutive clocks.
    @(negedge clk);
    #1 start1 = 1'b1; op1 = 2'd2; bit_sel1 = 3'd7; reg_in1 = 8'hFF;
    e = model(1, 2, 7, 0, 8'hFF, 0);
    @(negedge clk);
    chk("t1_first_reg_we", int'(reg_we1), 1);
    chk("t1_first_result", int'(result1), int'(e.res));
    chk("t1_first_done", int'(done1), 1);
    #1 op1 = 2'd1; bit_sel1 = 3'd0; reg_in1 = 8'hFF;
    e = model(1, 1, 0, 0, 8'hFF, 0);
    @(negedge clk);
    chk("t1_second_reg_we", int'(reg_we1), 1);
    chk("t1_second_result", int'(result1), int'(e.res));
    chk("t1_busy_held", int'(busy1), 1);
    #1 start1 = 1'b0;
    @(negedge clk);
    chk("t1_idle", int'(busy1), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
